uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Parametrised successor to the fixed four-source UART transmit mux. It merges N_CH byte sources into one UART transmit FIFO write port. Each source is an 8-bit frame whose low OP_W bits are its opcode. Sends are triggered by change-detect, a per-channel force pulse, or a periodic refresh. Arbitration is round-robin, writes honour tx_full, and writes are spaced by a programmable gap. It sits between the game controllers (state select, shoot, mouse, score, ...) and u_uart.

Parameters:
N_CH, 4, number of source channels (2..8)
BYTE_W, 8, frame width; equals UART word width
OP_W, 3, opcode field width, frame bits [OP_W-1:0]
GAP_CYCLES, 0, idle clocks enforced after each FIFO write (0 = none)
REFRESH_CYCLES, 0, period of forced resend of all enabled channels (0 = refresh disabled)

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  reset, asynchronous, active-low
ch_data  in  N_CH*BYTE_W  frame of channel i at bits [i*BYTE_W +: BYTE_W]
ch_en  in  N_CH  channel i may request
ch_force  in  N_CH  one-cycle pulse; resend channel i even if unchanged
tx_full  in  1  UART TX FIFO full
w_data  out  BYTE_W  frame to FIFO
wr_uart  out  1  FIFO write strobe
grant_ch  out  $clog2(N_CH)  channel of the current/last frame
op_code_data  out  OP_W  w_data[OP_W-1:0], sent-opcode feedback to sources
busy  out  1  state != IDLE

Behaviour:
- Reset (asserted low, asynchronous) values:
  - w_data=0, grant_ch=N_CH-1, state IDLE, wr_uart=0, busy=0.
  - last_sent[i]=0, flag[i]=0, refresh counter=0, gap counter=0.
  - Effect: the first arbitration favours ch0. A nonzero ch_data after reset is a change and is sent.
  - Reset mid-SEND drops the frame; wr_uart falls low immediately.
- Request: req[i] = ch_en[i] & (ch_data[i] != last_sent[i] | flag[i]).
  - The change part is a live compare. If data reverts to last_sent before grant and flag is clear, the request is cancelled.
- flag[i]: set by ch_force[i] or by a refresh tick (for all i where ch_en[i]); cleared when channel i is granted.
  - Set wins over clear in the same cycle, so the channel is resent later.
- Refresh counter, only when REFRESH_CYCLES>0:
  - counts 0..REFRESH_CYCLES-1, free-running;
  - the tick occurs in the cycle the count is REFRESH_CYCLES-1, then it wraps to 0.
- FSM states: IDLE, SEND, GAP.
  - IDLE: if any req, pick grant g by round-robin, searching from (grant_ch+1) mod N_CH upward with wrap. On the edge: w_data<=ch_data[g], last_sent[g]<=ch_data[g], grant_ch<=g, clear flag[g], go to SEND. Otherwise stay in IDLE.
  - SEND: wr_uart = ~tx_full (combinational from state and tx_full).
    - If ~tx_full: the write happens this cycle. Next state is GAP if GAP_CYCLES>0 (gap counter loaded with GAP_CYCLES-1), else IDLE.
    - If tx_full: stay in SEND; w_data and grant_ch are held; wr_uart=0.
    - The frame is committed: deasserting ch_en or changing ch_data while in SEND does not alter or cancel it.
  - GAP: decrement the counter; at 0 go to IDLE. No requests are evaluated.
- Latency, with IDLE and tx_full=0: ch_data change in cycle t gives wr_uart high in cycle t+1. Throughput is one frame per 2+GAP_CYCLES clocks.
- Ordering: with all channels continuously requesting, grants cycle 0,1,..,N_CH-1,0; no channel is starved.
- wr_uart is never high for two consecutive cycles. w_data is stable throughout SEND.
- Width rules: counters sized $clog2(max(value,2)); grant arithmetic is modulo N_CH, not a power-of-two wrap.

Decomposition:
- game_pkg: tx_arb_state enum (IDLE/SEND/GAP), opcode localparams (OP_CONNECT, OP_SHOT, OP_KEEPER, OP_SCORE), UART_BYTE_W=8.
- Sub-module rr_arbiter (param N): inputs req, last grant; outputs one-hot grant and index. This is pure combinational round-robin logic and is reused by future RX-side arbitration.

Test Plan:
- Post-reset, N_CH=4, ch_data={0x00,0x00,0x0B,0x00}, ch_en=4'hF, tx_full=0 -> exactly one write, w_data=0x0B, grant_ch=2, then idle.
- All four channels changed in the same cycle, GAP_CYCLES=0 -> writes in order ch0,ch1,ch2,ch3 on every 2nd clock; each wr_uart lasts one cycle.
- tx_full=1 for 5 cycles during SEND -> wr_uart=0 and w_data held for 5 cycles, then one write. Changing ch_data meanwhile does not alter the frame; it is sent as a following frame.
- Channel 1 data toggles 0x11->0x22->0x11 within 1 cycle while another channel is in SEND -> no frame sent for ch1.
- ch_force[3] pulse on unchanged data -> one resend of ch3. Force coincident with its grant -> two frames for ch3.
- REFRESH_CYCLES=16, ch_en=4'b0101, static data -> ch0 and ch2 resent every 16 clocks; ch1 and ch3 never resent. Async reset mid-GAP -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the game-side UART transmit path
//
// Purpose: arbiter FSM state type, opcode values carried in frame bits [2:0],
//          and the UART word width.
// Ports:   none (package).

package game_pkg;

    localparam int UART_BYTE_W = 8;

    localparam logic [2:0] OP_CONNECT = 3'd1;
    localparam logic [2:0] OP_SHOT    = 3'd2;
    localparam logic [2:0] OP_KEEPER  = 3'd3;
    localparam logic [2:0] OP_SCORE   = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_arb_state;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose: picks the first requester after the last granted index, wrapping modulo N.
// Ports:
//   i_req   [N-1:0]  request vector
//   i_last  [IW-1:0] index granted last time
//   o_grant [N-1:0]  one-hot grant (all zero when no request)
//   o_idx   [IW-1:0] index of the granted requester (0 when no request)

module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx
);

    // Scan from the farthest candidate to the nearest so the nearest
    // requester after i_last is the one left standing.
    always_comb begin
        int cand;
        o_grant = '0;
        o_idx   = '0;
        cand    = 0;
        for (int k = N; k >= 1; k--) begin
            cand = (int'(i_last) + k) % N;
            if (i_req[cand]) begin
                o_grant       = '0;
                o_grant[cand] = 1'b1;
                o_idx         = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - merges N_CH byte sources into one UART TX FIFO write port
//
// Purpose: change-detect / force / periodic-refresh send requests, round-robin
//          arbitration, tx_full back-pressure and a programmable inter-write gap.
// Ports:
//   clk           system clock
//   rst           asynchronous active-low reset
//   ch_data       N_CH frames, channel i at [i*BYTE_W +: BYTE_W]
//   ch_en         per-channel request enable
//   ch_force      per-channel one-cycle resend pulse
//   tx_full       UART TX FIFO full
//   w_data        frame to FIFO
//   wr_uart       FIFO write strobe
//   grant_ch      channel of the current/last frame
//   op_code_data  opcode field of w_data
//   busy          arbiter not idle

module uart_tx_arbiter
    import game_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int BYTE_W         = UART_BYTE_W,
    parameter int OP_W           = 3,
    parameter int GAP_CYCLES     = 0,
    parameter int REFRESH_CYCLES = 0,
    parameter int CH_W           = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH*BYTE_W-1:0]   ch_data,
    input  logic [N_CH-1:0]          ch_en,
    input  logic [N_CH-1:0]          ch_force,
    input  logic                     tx_full,
    output logic [BYTE_W-1:0]        w_data,
    output logic                     wr_uart,
    output logic [CH_W-1:0]          grant_ch,
    output logic [OP_W-1:0]          op_code_data,
    output logic                     busy
);

    localparam int GAP_W = $clog2((GAP_CYCLES > 2) ? GAP_CYCLES : 2);
    localparam int REF_W = $clog2((REFRESH_CYCLES > 2) ? REFRESH_CYCLES : 2);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    tx_arb_state       r_state;
    tx_arb_state       w_state_nxt;
    logic [BYTE_W-1:0] r_last_sent [N_CH];
    logic [BYTE_W-1:0] w_frame     [N_CH];
    logic [N_CH-1:0]   r_flag;
    logic [N_CH-1:0]   w_req;
    logic [N_CH-1:0]   w_gnt_oh;
    logic [N_CH-1:0]   w_set;
    logic [CH_W-1:0]   w_gnt_idx;
    logic [CH_W-1:0]   r_grant;
    logic [BYTE_W-1:0] r_w_data;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic              w_tick;
    logic              w_take;
    logic              w_write;

    // The change term is a live compare, so a value that reverts before
    // being granted drops its request without any extra state.
    for (genvar i = 0; i < N_CH; i++) begin : g_req
        assign w_frame[i] = ch_data[i*BYTE_W +: BYTE_W];
        assign w_req[i]   = ch_en[i] & ((w_frame[i] != r_last_sent[i]) | r_flag[i]);
    end

    rr_arbiter #(
        .N  (N_CH),
        .IW (CH_W)
    ) u_rr (
        .i_req   (w_req),
        .i_last  (r_grant),
        .o_grant (w_gnt_oh),
        .o_idx   (w_gnt_idx)
    );

    if (REFRESH_CYCLES > 0) begin : g_ref
        logic [REF_W-1:0] r_ref_cnt;

        assign w_tick = (r_ref_cnt == REF_W'(REFRESH_CYCLES - 1));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_ref_cnt <= '0;
            end else if (w_tick) begin
                r_ref_cnt <= '0;
            end else begin
                r_ref_cnt <= r_ref_cnt + 1'b1;
            end
        end
    end else begin : g_no_ref
        assign w_tick = 1'b0;
    end

    assign w_set = ch_force | ({N_CH{w_tick}} & ch_en);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_write     = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_take      = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (!tx_full) begin
                    w_write     = 1'b1;
                    w_state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_w_data  <= '0;
            r_grant   <= CH_W'(N_CH - 1);
            r_flag    <= '0;
            r_gap_cnt <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_last_sent[i] <= '0;
            end
        end else begin
            // Set is OR-ed after the clear so a force landing on the grant edge survives.
            r_flag <= (r_flag & ~({N_CH{w_take}} & w_gnt_oh)) | w_set;
            if (w_take) begin
                r_w_data               <= w_frame[w_gnt_idx];
                r_last_sent[w_gnt_idx] <= w_frame[w_gnt_idx];
                r_grant                <= w_gnt_idx;
            end
            if (w_write) begin
                r_gap_cnt <= GAP_LOAD;
            end else if (r_state == GAP && r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end
        end
    end

    assign wr_uart      = w_write;
    assign w_data       = r_w_data;
    assign grant_ch     = r_grant;
    assign op_code_data = r_w_data[OP_W-1:0];
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter

module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst_a, rst_b;
    logic [31:0] a_data, b_data;
    logic [3:0]  a_en, b_en, a_force, b_force;
    logic        a_full, b_full;
    logic [7:0]  a_wdata, b_wdata;
    logic        a_wr, b_wr;
    logic [1:0]  a_grant, b_grant;
    logic [2:0]  a_op, b_op;
    logic        a_busy, b_busy;

    uart_tx_arbiter dut_a (
        .clk(clk), .rst(rst_a), .ch_data(a_data), .ch_en(a_en), .ch_force(a_force),
        .tx_full(a_full), .w_data(a_wdata), .wr_uart(a_wr), .grant_ch(a_grant),
        .op_code_data(a_op), .busy(a_busy)
    );

    uart_tx_arbiter #(.GAP_CYCLES(2), .REFRESH_CYCLES(16)) dut_b (
        .clk(clk), .rst(rst_b), .ch_data(b_data), .ch_en(b_en), .ch_force(b_force),
        .tx_full(b_full), .w_data(b_wdata), .wr_uart(b_wr), .grant_ch(b_grant),
        .op_code_data(b_op), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  en;
        logic [2:0]  n;
        logic [7:0]  chs;
        logic [31:0] ds;
    } vec_t;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] d;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    vec_t vecs[7];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic a_wr_prev = 1'b0;

    int b_cnt[4];
    int b_last0     = -1;
    int b_snap[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] ch, input logic [7:0] d);
        exp_t e;
        e.ch = ch;
        e.d  = d;
        q.push_back(e);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (q.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        chk(name, q.size(), 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_wr) begin
            chk("no_back_to_back", a_wr_prev, 1'b0);
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got ch%0d data %0h expected no write", a_grant, a_wdata);
            end else begin
                e_mon = q.pop_front();
                chk("w_data", a_wdata, e_mon.d);
                chk("grant_ch", a_grant, e_mon.ch);
                chk("op_code_data", a_op, e_mon.d[2:0]);
            end
        end
        a_wr_prev = a_wr;
    end

    always @(negedge clk) begin
        if (!rst_b) begin
            b_last0 = -1;
        end else if (b_wr) begin
            b_cnt[b_grant] = b_cnt[b_grant] + 1;
            if (b_grant == 2'd0) begin
                if (b_last0 >= 0) chk("refresh_period", cyc - b_last0, 16);
                b_last0 = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) b_cnt[i] = 0;
        vecs[0] = '{32'h44332211, 4'hF,    3'd4, 8'b11_10_01_00, 32'h44332211};
        vecs[1] = '{32'h44332211, 4'hF,    3'd0, 8'h00,          32'h0};
        vecs[2] = '{32'h440B2211, 4'hF,    3'd1, 8'h02,          32'h0000000B};
        vecs[3] = '{32'h550B6611, 4'b0101, 3'd0, 8'h00,          32'h0};
        vecs[4] = '{32'h550B6611, 4'hF,    3'd2, 8'b0000_01_11,  32'h00006655};
        vecs[5] = '{32'h01020304, 4'b1001, 3'd2, 8'b0000_00_11,  32'h00000401};
        vecs[6] = '{32'h01020304, 4'hF,    3'd2, 8'b0000_10_01,  32'h00000203};

        rst_a = 1'b0; rst_b = 1'b0;
        a_data = '0; a_en = 4'hF; a_force = '0; a_full = 1'b0;
        b_data = 32'h000C000A; b_en = 4'b0101; b_force = '0; b_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_w_data", a_wdata, 8'h00);
        chk("rst_wr_uart", a_wr, 1'b0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_grant_ch", a_grant, 2'd3);
        chk("rst_b_grant_ch", b_grant, 2'd3);
        @(posedge clk); #1;
        rst_a = 1'b1; rst_b = 1'b1;

        for (int v = 0; v < 7; v++) begin
            @(posedge clk); #1;
            a_data = vecs[v].data;
            a_en   = vecs[v].en;
            for (int k = 0; k < 4; k++) begin
                if (k < int'(vecs[v].n)) push(vecs[v].chs[2*k +: 2], vecs[v].ds[8*k +: 8]);
            end
            drain($sformatf("vec%0d_drain", v));
        end

        // single-cycle latency from a data change
        @(posedge clk); #1;
        a_data[7:0] = 8'h77;
        push(2'd0, 8'h77);
        @(negedge clk);
        chk("latency_t_wr", a_wr, 1'b0);
        @(negedge clk);
        chk("latency_t1_wr", a_wr, 1'b1);
        drain("latency_drain");

        // back-pressure: frame held while full, later change sent afterwards
        @(posedge clk); #1;
        a_full = 1'b1;
        a_data[7:0] = 8'h5A;
        push(2'd0, 8'h5A);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("full_hold_wr", a_wr, 1'b0);
            chk("full_hold_data", a_wdata, 8'h5A);
            if (i == 1) begin
                a_data[7:0] = 8'h6B;
                push(2'd0, 8'h6B);
            end
        end
        @(posedge clk); #1;
        a_full = 1'b0;
        drain("full_drain");

        // ch1 glitch 0x11->0x22->0x11 while ch0 sits in SEND
        @(posedge clk); #1;
        a_data[15:8] = 8'h11;
        push(2'd1, 8'h11);
        drain("ch1_setup_drain");
        @(posedge clk); #1;
        a_full = 1'b1;
        a_data[7:0] = 8'h21;
        push(2'd0, 8'h21);
        @(posedge clk); #1;
        chk("glitch_busy", a_busy, 1'b1);
        a_data[15:8] = 8'h22;
        @(posedge clk); #1;
        a_data[15:8] = 8'h11;
        @(posedge clk); #1;
        a_full = 1'b0;
        drain("glitch_drain");

        // force on unchanged data, then force coincident with grant
        @(posedge clk); #1;
        a_force = 4'b1000;
        push(2'd3, 8'h01);
        @(posedge clk); #1;
        a_force = 4'b0000;
        drain("force_drain");
        @(posedge clk); #1;
        a_data[31:24] = 8'h31;
        a_force = 4'b1000;
        push(2'd3, 8'h31);
        push(2'd3, 8'h31);
        @(posedge clk); #1;
        a_force = 4'b0000;
        drain("force_grant_drain");

        // refresh on dut_b: exactly four resends of ch0 and ch2 in any 64 clocks
        @(negedge clk);
        for (int i = 0; i < 4; i++) b_snap[i] = b_cnt[i];
        repeat (64) @(negedge clk);
        chk("refresh_ch0", b_cnt[0] - b_snap[0], 4);
        chk("refresh_ch1", b_cnt[1] - b_snap[1], 0);
        chk("refresh_ch2", b_cnt[2] - b_snap[2], 4);
        chk("refresh_ch3", b_cnt[3] - b_snap[3], 0);

        // asynchronous reset while dut_b is in GAP
        begin
            int k;
            k = 0;
            @(negedge clk);
            while (!b_wr && k < 40) begin
                @(negedge clk);
                k++;
            end
            chk("gap_wait_write", b_wr, 1'b1);
        end
        @(posedge clk); #2;
        chk("gap_busy", b_busy, 1'b1);
        chk("gap_wr", b_wr, 1'b0);
        rst_b = 1'b0;
        #1;
        chk("gap_rst_w_data", b_wdata, 8'h00);
        chk("gap_rst_wr", b_wr, 1'b0);
        chk("gap_rst_busy", b_busy, 1'b0);
        chk("gap_rst_grant", b_grant, 2'd3);
        chk("gap_rst_op", b_op, 3'd0);
        @(posedge clk); #1;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
